rhscan_arb: RTL and testbench
=============================

Name: rhscan_arb

Overview:
- Parametrised round-robin completion monitor and arbiter for the RH11 SD-controller path.
- Grants one of NUM_CH drive requesters exclusive access to the SD controller through a one-hot REQ/ACK handshake.
- Beyond the fixed 8-drive scanner it adds:
  - a configurable channel count;
  - a skip-ahead scan mode;
  - a per-channel enable mask;
  - post-grant pointer advance for fairness;
  - an optional busy watchdog.
- Sits between the RPxx drive instances and the SD controller inside the RH11.

Parameters:
- NUM_CH, 8, number of requesting channels; legal range 2..16, non-power-of-two allowed.
- SCAN_MODE, 0, 0 = step the pointer one channel per clock; 1 = skip-ahead to the next eligible requester in one clock.
- TIMEOUT, 1024, maximum BUSY cycles before the watchdog fires; legal range 2..65535 (used only with the optional feature).
- Localparam SCAN_W = max(1, clog2(NUM_CH)).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- sdREQ  input  NUM_CH  per-channel SD request; level, held until service is complete.
- chEN  input  NUM_CH  per-channel enable mask; 1 = eligible for grant.
- sdACK  output  NUM_CH  one-hot grant; all zero when idle.
- scan  output  SCAN_W  current scan pointer / granted channel number.
- busy  output  1  high while a grant is outstanding (state BUSY).
- tmo  output  1  one-cycle pulse when the watchdog aborts a grant.
- tmoCH  output  SCAN_W  channel number of the last aborted grant; holds its value until the next abort.

Behaviour:
- Reset (rst = 0, asynchronous):
  - scan = 0, sdACK = 0, busy = 0, tmo = 0, tmoCH = 0.
  - state = IDLE, watchdog counter = 0, fault mask = 0.
  - Applies at any time, including mid-grant; sdACK drops without waiting for a clock edge.
- Eligibility: channel i is eligible when sdREQ[i] & chEN[i] & ~fault[i].
- State IDLE, SCAN_MODE 0:
  - If channel scan is eligible: sdACK <= one-hot(scan), state <= BUSY, busy <= 1.
  - Otherwise scan <= scan + 1, wrapping from NUM_CH-1 to 0.
- State IDLE, SCAN_MODE 1:
  - Combinationally select the first eligible channel searching scan, scan+1, … with wrap-around.
  - If one exists: scan <= that channel, sdACK <= its one-hot, state <= BUSY, all in the same clock. Latency from REQ to ACK is 1 clock.
  - If none exists: hold scan.
- State BUSY:
  - Only sdREQ[scan] is monitored.
  - chEN changes and other channels' requests are ignored for the current grant.
  - When sdREQ[scan] = 0: sdACK <= 0, busy <= 0, state <= DONE.
- State DONE:
  - scan <= scan + 1 (wrap), state <= IDLE.
  - This guarantees the last-served channel is examined last on the next pass.
- Grant properties:
  - At most one sdACK bit is high in any cycle.
  - sdACK changes only on IDLE→BUSY and BUSY→DONE transitions (or reset).
- Minimum cycle from grant to the next possible grant: REQ drop, then DONE, then IDLE; 3 clocks after REQ falls in SCAN_MODE 1.
- Simultaneous requests: the winner is the first eligible channel at or after scan.
- A request arriving at the same edge the pointer passes its channel waits for the next revolution (mode 0).
- Worst-case wait with N active channels: N grants.
- Mode 0 with no requests: the pointer free-runs continuously.

Optional Feature:
- Macro: RHSCAN_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on IDLE→BUSY and increments each BUSY clock.
  - When the counter reaches TIMEOUT-1 while sdREQ[scan] is still 1:
    - sdACK <= 0, busy <= 0, tmo <= 1 for one clock, tmoCH <= scan, fault[scan] <= 1, state <= DONE.
  - fault[i] clears when sdREQ[i] is observed low, so the drive must drop REQ before it can be regranted.
  - A normal REQ drop on the same cycle the counter expires is a normal completion: no tmo, no fault set.
- Undefined:
  - No counter and no fault mask logic; fault is treated as constant 0.
  - tmo and tmoCH are tied to 0.
  - BUSY waits indefinitely.

Test Plan:
- Reset and idle:
  - NUM_CH = 8, mode 0: release rst with sdREQ = 0 → sdACK = 0 and busy = 0.
  - scan counts 0,1,…,7,0 on successive clocks.
- Mode 0 single request:
  - Assert sdREQ = 8'h20 while scan = 2 → sdACK = 8'h20 one clock after scan reaches 5.
  - Drop REQ → sdACK = 0 next clock; scan = 6 two clocks after the drop.
- Mode 1 fairness:
  - Hold sdREQ = 8'h09 continuously, each grant dropping its REQ after 3 clocks and re-raising it once the next grant is issued.
  - Grants alternate ch0, ch3, ch0, ch3; never the same channel twice in a row.
- Mask and non-power-of-two:
  - NUM_CH = 5, mode 1, chEN = 5'b11101, sdREQ = 5'b00110.
  - Only ch2 is granted; ch1 never gets sdACK.
  - scan wraps 4→0 with no 5,6,7 values.
- Watchdog (RHSCAN_TIMEOUT_EN, TIMEOUT = 16):
  - Hold sdREQ[3] high → sdACK[3] drops after 16 BUSY clocks, with a 1-clock tmo and tmoCH = 3.
  - ch3 is not regranted until sdREQ[3] falls and rises again.
- Reset mid-grant:
  - Pull rst low while sdACK = 8'h10 → sdACK = 0 and busy = 0 immediately (before the next clk edge).
  - scan = 0 after release.

Source files
------------

// File: rtl/rhscan_arb.sv
// rtl/rhscan_arb.sv - round-robin REQ/ACK arbiter and completion monitor for the RH11 SD-controller path
// Optional busy watchdog: define RHSCAN_TIMEOUT_EN.
module rhscan_arb #(
    parameter int NUM_CH    = 8,
    parameter int SCAN_MODE = 0,
    parameter int TIMEOUT   = 1024,
    localparam int SCAN_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sdREQ,
    input  logic [NUM_CH-1:0] chEN,
    output logic [NUM_CH-1:0] sdACK,
    output logic [SCAN_W-1:0] scan,
    output logic              busy,
    output logic              tmo,
    output logic [SCAN_W-1:0] tmoCH
);
    localparam int SW1 = SCAN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [SCAN_W-1:0] r_scan;
    logic [SCAN_W-1:0] w_scan_inc;
    logic [SCAN_W-1:0] w_pick;
    logic [NUM_CH-1:0] w_fault;
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_scan_oh;
    logic              w_found;
    logic              w_grant;
    logic              w_req_cur;
    logic              w_abort;

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("rhscan_arb: parameter out of range");
    end

    assign w_elig     = sdREQ & chEN & ~w_fault;
    assign w_scan_oh  = {{(NUM_CH-1){1'b0}}, 1'b1} << r_scan;
    assign w_scan_inc = (r_scan == SCAN_W'(NUM_CH - 1)) ? '0 : r_scan + 1'b1;
    assign w_req_cur  = sdREQ[r_scan];

    // Skip-ahead search: walk from the farthest offset back so the nearest eligible channel wins.
    always_comb begin
        logic [SW1-1:0] v_sum;
        v_sum   = '0;
        w_found = 1'b0;
        w_pick  = r_scan;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_scan} + SW1'(k);
            if (v_sum >= SW1'(NUM_CH)) begin
                v_sum = v_sum - SW1'(NUM_CH);
            end
            if (w_elig[v_sum[SCAN_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v_sum[SCAN_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant = (SCAN_MODE != 0) ? w_found : w_elig[r_scan];
    end

`ifdef RHSCAN_TIMEOUT_EN
    logic [15:0]       r_cnt;
    logic [NUM_CH-1:0] r_fault;
    logic              r_tmo;
    logic [SCAN_W-1:0] r_tmo_ch;

    assign w_fault = r_fault;
    // A REQ drop on the expiry cycle has w_req_cur low, so it completes normally.
    assign w_abort = (r_state == S_BUSY) & w_req_cur & (r_cnt == 16'(TIMEOUT - 1));
    assign tmo     = r_tmo;
    assign tmoCH   = r_tmo_ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_fault  <= '0;
            r_tmo    <= 1'b0;
            r_tmo_ch <= '0;
        end else begin
            if (r_state == S_IDLE && w_grant) begin
                r_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 16'd1;
            end
            r_fault <= (r_fault & sdREQ) | (w_abort ? w_scan_oh : '0);
            r_tmo   <= w_abort;
            if (w_abort) begin
                r_tmo_ch <= r_scan;
            end
        end
    end
`else
    assign w_fault = '0;
    assign w_abort = 1'b0;
    assign tmo     = 1'b0;
    assign tmoCH   = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_BUSY;
            S_BUSY:  if (!w_req_cur || w_abort) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stepping past the served channel after DONE makes it the last one examined next pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (SCAN_MODE != 0) begin
                        if (w_found) r_scan <= w_pick;
                    end else if (!w_grant) begin
                        r_scan <= w_scan_inc;
                    end
                end
                S_DONE:  r_scan <= w_scan_inc;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy  = (r_state == S_BUSY);
        sdACK = (r_state == S_BUSY) ? w_scan_oh : '0;
        scan  = r_scan;
    end
endmodule

// File: tb/tb_rhscan_arb.sv
// tb/tb_rhscan_arb.sv - randomized and directed self-checking bench for rhscan_arb
module tb_rhscan_arb;
    localparam int TMO_LIM = 16;
`ifdef RHSCAN_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] req0 = '0, en0 = 8'hFF, ack0;
    logic [4:0] req1 = '0, en1 = 5'h1F, ack1;
    logic [7:0] req2 = '0, en2 = 8'hFF, ack2;
    logic [2:0] scan0, scan1, scan2, tch0, tch1, tch2;
    logic       busy0, busy1, busy2, tmo0, tmo1, tmo2;

    rhscan_arb #(.NUM_CH(8), .SCAN_MODE(0), .TIMEOUT(TMO_LIM)) dut0 (
        .clk(clk), .rst(rst_n), .sdREQ(req0), .chEN(en0), .sdACK(ack0),
        .scan(scan0), .busy(busy0), .tmo(tmo0), .tmoCH(tch0));
    rhscan_arb #(.NUM_CH(5), .SCAN_MODE(1), .TIMEOUT(TMO_LIM)) dut1 (
        .clk(clk), .rst(rst_n), .sdREQ(req1), .chEN(en1), .sdACK(ack1),
        .scan(scan1), .busy(busy1), .tmo(tmo1), .tmoCH(tch1));
    rhscan_arb #(.NUM_CH(8), .SCAN_MODE(1), .TIMEOUT(TMO_LIM)) dut2 (
        .clk(clk), .rst(rst_n), .sdREQ(req2), .chEN(en2), .sdACK(ack2),
        .scan(scan2), .busy(busy2), .tmo(tmo2), .tmoCH(tch2));

    int checks = 0;
    int failures = 0;

    // Model: owner is the granted channel (-1 when none), done marks the post-release cycle.
    typedef struct packed {
        int          ptr;
        int          owner;
        logic        done;
        int          cnt;
        logic [15:0] fault;
        logic        tmo;
        int          tmoch;
    } mst_t;

    function automatic mst_t mreset();
        mst_t r;
        r.ptr = 0; r.owner = -1; r.done = 1'b0; r.cnt = 0;
        r.fault = '0; r.tmo = 1'b0; r.tmoch = 0;
        return r;
    endfunction

    function automatic mst_t mstep(mst_t s, int n, int mode, logic [15:0] req, logic [15:0] en);
        mst_t        r;
        logic [15:0] elig;
        bit          found;
        r     = s;
        elig  = req & en & ~s.fault;
        r.tmo = 1'b0;
        r.fault = WD ? (s.fault & req) : 16'h0;
        if (s.done) begin
            r.done = 1'b0;
            r.ptr  = (s.ptr + 1) % n;
        end else if (s.owner >= 0) begin
            if (!req[s.owner]) begin
                r.owner = -1; r.done = 1'b1;
            end else if (WD && s.cnt == TMO_LIM - 1) begin
                r.owner = -1; r.done = 1'b1; r.tmo = 1'b1;
                r.tmoch = s.owner; r.fault[s.owner] = 1'b1;
            end else begin
                r.cnt = s.cnt + 1;
            end
        end else if (mode == 0) begin
            if (elig[s.ptr]) begin
                r.owner = s.ptr; r.cnt = 0;
            end else begin
                r.ptr = (s.ptr + 1) % n;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (!found && elig[(s.ptr + k) % n]) begin
                    found = 1'b1; r.owner = (s.ptr + k) % n; r.ptr = r.owner; r.cnt = 0;
                end
            end
        end
        return r;
    endfunction

    mst_t m0, m1, m2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= mreset(); m1 <= mreset(); m2 <= mreset();
        end else begin
            m0 <= mstep(m0, 8, 0, 16'(req0), 16'(en0));
            m1 <= mstep(m1, 5, 1, 16'(req1), 16'(en1));
            m2 <= mstep(m2, 8, 1, 16'(req2), 16'(en2));
        end
    end

    task automatic cmp(string nm, logic [15:0] ack, int sc, logic bz, logic tm, int tc, mst_t m);
        logic [15:0] e_ack;
        e_ack = (m.owner >= 0) ? (16'h1 << m.owner) : 16'h0;
        checks++;
        if (ack !== e_ack || sc != m.ptr || bz !== (m.owner >= 0) || tm !== m.tmo || tc != m.tmoch) begin
            failures++;
            $display("FAIL %s t=%0t ack=%h/%h scan=%0d/%0d busy=%b/%b tmo=%b/%b tmoCH=%0d/%0d (actual/required)",
                     nm, $time, ack, e_ack, sc, m.ptr, bz, (m.owner >= 0), tm, m.tmo, tc, m.tmoch);
        end
    endtask

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    function automatic int oh_idx(logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        cmp("model_dut0", 16'(ack0), int'(scan0), busy0, tmo0, int'(tch0), m0);
        cmp("model_dut1", 16'(ack1), int'(scan1), busy1, tmo1, int'(tch1), m1);
        cmp("model_dut2", 16'(ack2), int'(scan2), busy2, tmo2, int'(tch2), m2);
    end

    initial begin
        int t, n1, n2, hold, dropped, cnt;
        int gch[4];
        repeat (3) @(negedge clk);
        chk("reset_ack", int'(ack0), 0);
        chk("reset_busy", int'(busy0), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            chk("scan_freerun", int'(scan0), k % 8);
            @(negedge clk);
        end

        t = 0;
        while (scan0 != 3'd2 && t < 16) begin @(negedge clk); t++; end
        chk("wait_scan2", int'(scan0), 2);
        req0 = 8'h20;
        repeat (3) @(negedge clk);
        chk("m0_scan_at5", int'(scan0), 5);
        chk("m0_no_ack_yet", int'(ack0), 0);
        @(negedge clk);
        chk("m0_ack20", int'(ack0), 'h20);
        repeat (2) @(negedge clk);
        req0 = 8'h00;
        @(negedge clk);
        chk("m0_ack_drop", int'(ack0), 0);
        @(negedge clk);
        chk("m0_scan6", int'(scan0), 6);

        req0 = 8'h10;
        t = 0;
        while (ack0 != 8'h10 && t < 20) begin @(negedge clk); t++; end
        chk("m0_ack10", int'(ack0), 'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ack", int'(ack0), 0);
        chk("async_rst_busy", int'(busy0), 0);
        req0 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_scan0", int'(scan0), 0);

        req2 = 8'h09;
        dropped = -1;
        for (int g = 0; g < 4; g++) begin
            t = 0;
            while (ack2 == 8'h00 && t < 20) begin @(negedge clk); t++; end
            gch[g] = oh_idx(16'(ack2));
            if (dropped >= 0) req2[dropped] = 1'b1;
            repeat (3) @(negedge clk);
            if (gch[g] >= 0) req2[gch[g]] = 1'b0;
            dropped = gch[g];
            @(negedge clk);
        end
        chk("fair_g0", gch[0], 0);
        chk("fair_g1", gch[1], 3);
        chk("fair_g2", gch[2], 0);
        chk("fair_g3", gch[3], 3);
        req2 = 8'h00;

        en1 = 5'b11101; req1 = 5'b00110;
        n1 = 0; n2 = 0; hold = 0;
        repeat (80) begin
            @(negedge clk);
            if (ack1[1]) n1++;
            if (ack1[2]) begin
                n2++; hold++;
                if (hold == 3) begin req1[2] = 1'b0; hold = 0; end
            end else if (!req1[2]) begin
                req1[2] = 1'b1;
            end
        end
        chk("mask_ch1_never", n1, 0);
        chk("mask_ch2_granted", (n2 > 0) ? 1 : 0, 1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req0 ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
            req1 ^= 5'($urandom) & 5'($urandom) & 5'($urandom);
            req2 ^= 8'($urandom) & 8'($urandom) & 8'($urandom);
            en0  ^= 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
            en1  ^= 5'($urandom) & 5'($urandom) & 5'($urandom) & 5'($urandom);
            en2  ^= 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
            if (c == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

`ifdef RHSCAN_TIMEOUT_EN
        req0 = 8'h00; en0 = 8'hFF;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 8'h08;
        t = 0;
        while (!ack0[3] && t < 20) begin @(negedge clk); t++; end
        cnt = 0;
        while (ack0[3] && cnt < 40) begin cnt++; @(negedge clk); end
        chk("wd_busy_cycles", cnt, TMO_LIM);
        chk("wd_tmo_pulse", int'(tmo0), 1);
        chk("wd_tmoch", int'(tch0), 3);
        @(negedge clk);
        chk("wd_tmo_one_cycle", int'(tmo0), 0);
        cnt = 0;
        repeat (30) begin @(negedge clk); if (ack0[3]) cnt++; end
        chk("wd_no_regrant", cnt, 0);
        req0 = 8'h00;
        @(negedge clk);
        req0 = 8'h08;
        t = 0;
        while (!ack0[3] && t < 20) begin @(negedge clk); t++; end
        chk("wd_regrant", int'(ack0[3]), 1);
        req0 = 8'h00;
`endif
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
